// File: rtl/layer1_sched_pkg.sv
// Shared geometry constants, FSM encoding and pool-tag rule for the first-layer sequencer.
package layer1_sched_pkg;

   localparam int IMG    = 32;             // frame width and height
   localparam int K      = 5;              // conv kernel size
   localparam int NCH    = 6;              // channel engines
   localparam int POOL   = 2;              // max-pool window size
   localparam int CONV_W = IMG - K + 1;    // 28
   localparam int POOL_W = CONV_W / POOL;  // 14

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_STREAM = 2'd1,
      S_DRAIN  = 2'd2,
      S_DONE   = 2'd3
   } state_t;

   // A pixel closes a pool window when it is the bottom-right corner of a
   // 2x2 block of valid conv outputs (odd offset from the first conv output).
   function automatic logic is_tag(input int r, input int c, input int k);
      return (r >= k - 1) && (c >= k - 1) &&
             (((r - k + 1) % 2) == 1) && (((c - k + 1) % 2) == 1);
   endfunction

endpackage

// File: rtl/layer1_out_ser.sv
// Hold register for one pooled group plus the group-to-single-stream serializer.
module layer1_out_ser #(
   parameter int OP = 8,
   parameter int NW = 6
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_cap,
   input  logic [NW*(OP+1)-1:0] i_data,
   input  logic                 i_ready,
   output logic                 o_valid,
   output logic [OP:0]          o_data,
   output logic [2:0]           o_ch,
   output logic                 o_empty,
   output logic                 o_grp_end
);

   logic [NW-1:0][OP:0] r_hold;
   logic [2:0]          r_idx;
   logic [2:0]          r_cnt;
   logic                w_fire;

   assign o_valid   = (r_cnt != 3'd0);
   assign o_empty   = !o_valid;
   assign w_fire    = o_valid && i_ready;
   assign o_grp_end = w_fire && (r_cnt == 3'd1);
   assign o_data    = o_valid ? r_hold[r_idx] : '0;
   assign o_ch      = r_idx;

   // Load a whole group on capture, then step through it one beat per handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hold <= '0;
         r_idx  <= '0;
         r_cnt  <= '0;
      end else if (i_cap) begin
         r_hold <= i_data;
         r_idx  <= '0;
         r_cnt  <= 3'(NW);
      end else if (w_fire) begin
         r_cnt <= r_cnt - 3'd1;
         r_idx <= (r_cnt == 3'd1) ? 3'd0 : r_idx + 3'd1;
      end
   end

endmodule

// File: rtl/layer1_sched.sv
// Frame sequencer: feeds pixels to the channel engines, tracks pool-window
// positions through the engine latency and serializes the pooled results.
module layer1_sched #(
   parameter int PP  = 8,
   parameter int OP  = 8,
   parameter int IMG = layer1_sched_pkg::IMG,
   parameter int K   = layer1_sched_pkg::K,
   parameter int NCH = layer1_sched_pkg::NCH,
   parameter int LAT = 3
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [PP:0]           in_pxl,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic [PP:0]           eng_pxl,
   output logic                  eng_en,
   input  logic [NCH*(OP+1)-1:0] eng_result,
   output logic [OP:0]           out_data,
   output logic [2:0]            out_ch,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   output logic                  busy,
   output logic                  done
);

   typedef layer1_sched_pkg::state_t state_t;

   localparam int CW   = $clog2(IMG);
   localparam int PW   = (IMG - K + 1) / layer1_sched_pkg::POOL;
   localparam int NGRP = PW * PW;
   localparam int GW   = $clog2(NGRP + 1);
   localparam int DW   = $clog2(LAT + 1);

   state_t         r_state, w_next;
   logic [CW-1:0]  r_row, r_col;
   logic [DW-1:0]  r_drain;
   logic [GW-1:0]  r_grp;
   logic [LAT-1:0] r_tag;

   logic w_tag_out, w_stall, w_cap, w_en, w_in_ready, w_tag_in, w_last_px;
   logic w_empty, w_valid, w_grp_end;
   logic [2:0] w_ch;

   // tag_out high means eng_result currently holds a finished pool window
   assign w_tag_out = r_tag[LAT-1];
   assign w_stall   = w_tag_out && !w_empty;
   assign w_cap     = w_tag_out && w_empty;
   assign w_last_px = (r_row == CW'(IMG - 1)) && (r_col == CW'(IMG - 1));

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) r_state <= layer1_sched_pkg::S_IDLE;
      else        r_state <= w_next;
   end

   // Next state, handshake and engine enable
   always_comb begin
      w_next     = r_state;
      w_in_ready = 1'b0;
      w_en       = 1'b0;
      w_tag_in   = 1'b0;
      case (r_state)
         layer1_sched_pkg::S_IDLE: begin
            if (start) w_next = layer1_sched_pkg::S_STREAM;
         end
         layer1_sched_pkg::S_STREAM: begin
            w_in_ready = !w_stall;
            w_en       = in_valid && !w_stall;
            w_tag_in   = layer1_sched_pkg::is_tag(int'(r_row), int'(r_col), K);
            if (w_en && w_last_px) w_next = layer1_sched_pkg::S_DRAIN;
         end
         layer1_sched_pkg::S_DRAIN: begin
            // flush the engine pipeline with zero pixels, then let the hold empty
            if (r_drain != DW'(LAT)) w_en = !w_stall;
            else if (w_empty)        w_next = layer1_sched_pkg::S_DONE;
         end
         layer1_sched_pkg::S_DONE: w_next = layer1_sched_pkg::S_IDLE;
         default:                  w_next = layer1_sched_pkg::S_IDLE;
      endcase
   end

   // Raster position in STREAM, flush count in DRAIN
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_row   <= '0;
         r_col   <= '0;
         r_drain <= '0;
      end else if (r_state == layer1_sched_pkg::S_IDLE) begin
         r_row   <= '0;
         r_col   <= '0;
         r_drain <= '0;
      end else if (w_en) begin
         if (r_state == layer1_sched_pkg::S_STREAM) begin
            if (r_col == CW'(IMG - 1)) begin
               r_col <= '0;
               r_row <= r_row + 1'b1;
            end else begin
               r_col <= r_col + 1'b1;
            end
         end else begin
            r_drain <= r_drain + 1'b1;
         end
      end
   end

   // Tag delay line tracks the engine pipeline; a capture without an engine
   // step retires the last stage so the same result is not taken twice.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)     r_tag <= '0;
      else if (w_en)  r_tag <= {r_tag[LAT-2:0], w_tag_in};
      else if (w_cap) r_tag[LAT-1] <= 1'b0;
   end

   // Index of the group being serialized; advances when a group finishes
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  r_grp <= '0;
      else if (r_state == layer1_sched_pkg::S_IDLE) r_grp <= '0;
      else if (w_grp_end)                          r_grp <= r_grp + 1'b1;
   end

   layer1_out_ser #(.OP(OP), .NW(NCH)) u_ser (
      .clk       (clk),
      .rst_n     (reset),
      .i_cap     (w_cap),
      .i_data    (eng_result),
      .i_ready   (out_ready),
      .o_valid   (w_valid),
      .o_data    (out_data),
      .o_ch      (w_ch),
      .o_empty   (w_empty),
      .o_grp_end (w_grp_end)
   );

   assign in_ready  = w_in_ready;
   assign eng_en    = w_en;
   assign eng_pxl   = (w_en && r_state == layer1_sched_pkg::S_STREAM) ? in_pxl : '0;
   assign out_valid = w_valid;
   assign out_ch    = w_ch;
   assign out_last  = w_valid && (r_grp == GW'(NGRP - 1)) && (w_ch == 3'(NCH - 1));
   assign busy      = (r_state != layer1_sched_pkg::S_IDLE);
   assign done      = (r_state == layer1_sched_pkg::S_DONE);

endmodule

// File: tb/tb_layer1_sched.sv
// Bench for layer1_sched: behavioural engine, raster-order scoreboard, scenario tasks.
module tb_layer1_sched;

   localparam int PP = 8, OP = 8, NCH = 6, LAT = 3, IMG = 32, NB = 196 * 6;

   logic clk = 1'b0, reset = 1'b0, start = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
   logic [PP:0] in_pxl = '0;
   logic in_ready, eng_en, out_valid, out_last, busy, done;
   logic [PP:0] eng_pxl;
   logic [OP:0] out_data;
   logic [2:0]  out_ch;
   logic [NCH*(OP+1)-1:0] eng_result;

   int checks = 0, errors = 0;

   always #5 clk = ~clk;

   layer1_sched #(.PP(PP), .OP(OP), .IMG(IMG), .K(5), .NCH(NCH), .LAT(LAT)) dut (
      .clk(clk), .reset(reset), .start(start), .in_pxl(in_pxl), .in_valid(in_valid),
      .in_ready(in_ready), .eng_pxl(eng_pxl), .eng_en(eng_en), .eng_result(eng_result),
      .out_data(out_data), .out_ch(out_ch), .out_valid(out_valid), .out_ready(out_ready),
      .out_last(out_last), .busy(busy), .done(done));

   // ---------------- engine model ----------------
   // Mode 0: channel c = row*2 + c of the pixel LAT steps back.
   // Mode 1: channel c = that pixel's value + 37*c (exercises the pixel path).
   int eng_mode = 0;
   int steps = 0;
   logic [PP:0] hist [0:2047];

   function automatic logic [OP:0] eng_val(input int p, input int c, input int mode,
                                           input logic [PP:0] px);
      if (mode == 0) return 9'((p / IMG) * 2 + c);
      return 9'(int'(px) + c * 37);
   endfunction

   always @(posedge clk or negedge reset) begin
      if (!reset) steps <= 0;
      else if (start && !busy) steps <= 0;
      else if (eng_en) begin
         if (steps < 2048) hist[steps] <= eng_pxl;
         steps <= steps + 1;
      end
   end

   always_comb begin
      eng_result = '0;
      if (steps >= LAT && steps - LAT < IMG * IMG)
         for (int c = 0; c < NCH; c++)
            eng_result[c*(OP+1) +: OP+1] = eng_val(steps - LAT, c, eng_mode, hist[steps - LAT]);
   end

   // ---------------- monitor ----------------
   typedef struct { logic [OP:0] d; logic [2:0] ch; logic last; } beat_t;
   beat_t beats[$];
   logic [PP:0] sent [0:16383];
   int cyc = 0, n_in = 0, n_done = 0, extra_en = 0, pxl_err = 0, stab_err = 0;
   int done_cyc = 0, last_cyc = 0;
   logic p_hold = 1'b0, p_last = 1'b0;
   logic [OP:0] p_d = '0;
   logic [2:0]  p_ch = '0;

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (in_valid && in_ready) begin
         if (n_in < 16384) sent[n_in] <= in_pxl;
         n_in <= n_in + 1;
         if (!eng_en || eng_pxl !== in_pxl) pxl_err <= pxl_err + 1;
      end else if (eng_en) begin
         extra_en <= extra_en + 1;
         if (eng_pxl !== '0) pxl_err <= pxl_err + 1;
      end
      if (out_valid && out_ready) begin
         beats.push_back('{out_data, out_ch, out_last});
         if (out_last) last_cyc <= cyc;
      end
      if (done) begin
         n_done   <= n_done + 1;
         done_cyc <= cyc;
      end
      if (reset && p_hold &&
          (!out_valid || out_data !== p_d || out_ch !== p_ch || out_last !== p_last))
         stab_err <= stab_err + 1;
      p_hold <= reset && out_valid && !out_ready;
      p_d    <= out_data;
      p_ch   <= out_ch;
      p_last <= out_last;
   end

   // Expected stream: pool windows close at odd offsets from the first conv
   // output, i.e. rows/cols 5,7,...,31, visited in raster order, six channels each.
   function automatic int score(input int in0, input int b0);
      int bad = 0, i = b0, n = 0;
      for (int r = 5; r < IMG; r += 2)
         for (int c = 5; c < IMG; c += 2)
            for (int ch = 0; ch < NCH; ch++) begin
               logic [OP:0] v;
               v = eng_val(r * IMG + c, ch, eng_mode, sent[in0 + r * IMG + c]);
               if (i >= beats.size()) bad++;
               else if (beats[i].d !== v || beats[i].ch !== 3'(ch) || beats[i].last !== (n == NB - 1))
                  bad++;
               i++;
               n++;
            end
      return bad;
   endfunction

   // ---------------- driver ----------------
   int bp_left = 0;
   logic bp_inr = 1'b1, bp_en = 1'b1, bp_ov = 1'b0;

   task automatic run_frame(input int vmode, input int rmode, input int start_at, output int ok);
      int d0 = n_done;
      logic bp_started = 1'b0;
      ok = 0;
      bp_left = 0;
      @(posedge clk); #1;
      start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 20000; k++) begin
         if (bp_left > 0) begin
            bp_left--;
            if (bp_left == 0) begin bp_inr = in_ready; bp_en = eng_en; bp_ov = out_valid; end
         end else if (rmode == 4 && !bp_started && out_valid) begin
            bp_left = 20;
            bp_started = 1'b1;
         end
         in_pxl = 9'($urandom);
         case (vmode)
            1:       in_valid = 1'b1;
            2:       in_valid = (k % 2 == 0);
            default: in_valid = ($urandom_range(3) != 0);
         endcase
         case (rmode)
            1:       out_ready = 1'b1;
            4:       out_ready = (bp_left == 0);
            default: out_ready = ($urandom_range(2) != 0);
         endcase
         start = (k == start_at);
         @(posedge clk); #1;
         if (n_done != d0) begin ok = 1; break; end
      end
      in_valid = 1'b0; out_ready = 1'b1; start = 1'b0;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset;
      #1;
      checks++;
      if ({in_ready, eng_en, eng_pxl, out_valid, out_data, out_ch, out_last, busy, done} !== '0) begin
         errors++;
         $display("FAIL reset_outputs: got %h expected 0",
                  {in_ready, eng_en, eng_pxl, out_valid, out_data, out_ch, out_last, busy, done});
      end
      repeat (3) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      repeat (3) @(posedge clk); #1;
      checks++;
      if ({busy, out_valid, in_ready} !== 3'b000) begin
         errors++;
         $display("FAIL idle_after_release: got busy/ov/ir=%b expected 000", {busy, out_valid, in_ready});
      end
   endtask

   task automatic test_reset_mid;
      int in0 = n_in, ov_seen = 0, ir_seen = 0;
      logic hit = 1'b0;
      eng_mode = 1;
      @(posedge clk); #1; start = 1'b1;
      @(posedge clk); #1; start = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
      for (int k = 0; k < 5000; k++) begin
         in_pxl = 9'($urandom);
         @(posedge clk); #1;
         if (n_in - in0 >= 100) begin hit = 1'b1; break; end
      end
      checks++;
      if (hit !== 1'b1) begin errors++; $display("FAIL mid_reach_100: got %0d transfers expected 100", n_in - in0); end
      reset = 1'b0;
      #1;
      checks++;
      if ({in_ready, eng_en, eng_pxl, out_valid, out_data, out_ch, out_last, busy, done} !== '0) begin
         errors++;
         $display("FAIL mid_reset_outputs: got %h expected 0",
                  {in_ready, eng_en, eng_pxl, out_valid, out_data, out_ch, out_last, busy, done});
      end
      repeat (2) @(posedge clk);
      @(negedge clk); reset = 1'b1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) ov_seen++;
         if (in_ready)  ir_seen++;
      end
      checks++;
      if (ov_seen != 0 || ir_seen != 0) begin
         errors++;
         $display("FAIL mid_no_output: got out_valid=%0d in_ready=%0d cycles expected 0", ov_seen, ir_seen);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %b expected 0", busy); end
      in_valid = 1'b0;
   endtask

   task automatic test_full_frame;
      int in0 = n_in, b0 = beats.size(), d0 = n_done, e0 = extra_en, p0 = pxl_err, s0 = stab_err, ok, bad;
      eng_mode = 1;
      run_frame(1, 1, -1, ok);
      repeat (3) @(posedge clk); #1;
      checks++;
      if (ok != 1) begin errors++; $display("FAIL full_timeout: got done=%0d expected 1", ok); end
      checks++;
      if (n_in - in0 != IMG * IMG) begin errors++; $display("FAIL full_inputs: got %0d expected %0d", n_in - in0, IMG * IMG); end
      checks++;
      if (beats.size() - b0 != NB) begin errors++; $display("FAIL full_beats: got %0d expected %0d", beats.size() - b0, NB); end
      bad = score(in0, b0);
      checks++;
      if (bad != 0) begin errors++; $display("FAIL full_stream: got %0d bad beats expected 0", bad); end
      checks++;
      if (n_done - d0 != 1) begin errors++; $display("FAIL full_done_count: got %0d expected 1", n_done - d0); end
      checks++;
      if (done_cyc <= last_cyc) begin errors++; $display("FAIL full_done_after_last: got done@%0d last@%0d expected later", done_cyc, last_cyc); end
      checks++;
      if (extra_en - e0 != LAT || pxl_err != p0) begin
         errors++;
         $display("FAIL full_engine: got drain_steps=%0d pxl_err=%0d expected %0d/0", extra_en - e0, pxl_err - p0, LAT);
      end
      checks++;
      if (stab_err != s0) begin errors++; $display("FAIL full_stability: got %0d expected 0", stab_err - s0); end
   endtask

   task automatic test_engine_values;
      int in0 = n_in, b0 = beats.size(), ok, bad;
      eng_mode = 0;
      run_frame(1, 1, -1, ok);
      checks++;
      if (ok != 1) begin errors++; $display("FAIL eng_timeout: got done=%0d expected 1", ok); end
      for (int c = 0; c < NCH; c++) begin
         checks++;
         if (beats.size() <= b0 + c || beats[b0 + c].d !== 9'(10 + c) || beats[b0 + c].ch !== 3'(c)) begin
            errors++;
            $display("FAIL eng_first_group_ch%0d: got %0d expected %0d", c,
                     (beats.size() > b0 + c) ? int'(beats[b0 + c].d) : -1, 10 + c);
         end
      end
      bad = score(in0, b0);
      checks++;
      if (bad != 0) begin errors++; $display("FAIL eng_stream: got %0d bad beats expected 0", bad); end
   endtask

   task automatic test_backpressure;
      int in0 = n_in, b0 = beats.size(), s0 = stab_err, ok, bad;
      eng_mode = 1;
      run_frame(1, 4, -1, ok);
      checks++;
      if (ok != 1) begin errors++; $display("FAIL bp_timeout: got done=%0d expected 1", ok); end
      checks++;
      if ({bp_inr, bp_en, bp_ov} !== 3'b001) begin
         errors++;
         $display("FAIL bp_stall: got in_ready/eng_en/out_valid=%b expected 001", {bp_inr, bp_en, bp_ov});
      end
      bad = score(in0, b0);
      checks++;
      if (bad != 0 || beats.size() - b0 != NB) begin
         errors++;
         $display("FAIL bp_stream: got %0d bad of %0d beats expected 0 of %0d", bad, beats.size() - b0, NB);
      end
      checks++;
      if (stab_err != s0) begin errors++; $display("FAIL bp_stability: got %0d expected 0", stab_err - s0); end
   endtask

   task automatic test_toggle_valid;
      int in0 = n_in, b0 = beats.size(), e0 = extra_en, p0 = pxl_err, ok, bad;
      eng_mode = 1;
      run_frame(2, 1, -1, ok);
      checks++;
      if (ok != 1) begin errors++; $display("FAIL tog_timeout: got done=%0d expected 1", ok); end
      bad = score(in0, b0);
      checks++;
      if (bad != 0 || beats.size() - b0 != NB) begin
         errors++;
         $display("FAIL tog_stream: got %0d bad of %0d beats expected 0 of %0d", bad, beats.size() - b0, NB);
      end
      checks++;
      if (extra_en - e0 != LAT || pxl_err != p0) begin
         errors++;
         $display("FAIL tog_eng_en: got non_transfer_steps=%0d pxl_err=%0d expected %0d/0", extra_en - e0, pxl_err - p0, LAT);
      end
   endtask

   task automatic test_start_ignored;
      int in0 = n_in, b0 = beats.size(), d0 = n_done, s0 = stab_err, ok, bad;
      eng_mode = 1;
      run_frame(3, 3, 300, ok);
      repeat (3) @(posedge clk); #1;
      checks++;
      if (ok != 1) begin errors++; $display("FAIL start_timeout: got done=%0d expected 1", ok); end
      checks++;
      if (n_in - in0 != IMG * IMG || beats.size() - b0 != NB) begin
         errors++;
         $display("FAIL start_counts: got in=%0d beats=%0d expected %0d/%0d", n_in - in0, beats.size() - b0, IMG * IMG, NB);
      end
      bad = score(in0, b0);
      checks++;
      if (bad != 0) begin errors++; $display("FAIL start_stream: got %0d bad beats expected 0", bad); end
      checks++;
      if (n_done - d0 != 1 || busy !== 1'b0 || stab_err != s0) begin
         errors++;
         $display("FAIL start_end: got done=%0d busy=%b stab=%0d expected 1/0/0", n_done - d0, busy, stab_err - s0);
      end
   endtask

   initial begin
      test_reset;
      test_reset_mid;
      test_full_frame;
      test_engine_values;
      test_backpressure;
      test_toggle_valid;
      test_start_ignored;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
